// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pipeline stages: sprite geometry, config
// addresses, sprite FSM states and the colour index type.
package vga_pkg;

    localparam int         SPR_W        = 16;
    localparam logic [4:0] SPR_ADDR_POS = 5'd16;
    localparam logic [4:0] SPR_ADDR_CLR = 5'd17;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        FETCH,
        ARMED,
        SHIFT,
        DONE
    } spr_state_t;

    typedef logic [1:0] color_idx_t;

endpackage

// File: rtl/vga_sprite_rowmem.sv
// Sprite row store: HEIGHT x 32-bit register file, one write port and one
// combinational read port (a same-cycle write is not visible to the read).
module vga_sprite_rowmem #(
    parameter int HEIGHT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [HEIGHT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HEIGHT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (HEIGHT == 16) begin : g_full
            assign rd_data = mem[rd_addr];
        end else begin : g_part
            assign rd_data = (int'(rd_addr) < HEIGHT) ? mem[rd_addr] : '0;
        end
    endgenerate

endmodule

// File: rtl/vga_sprite.sv
// Single 16 px x HEIGHT, 2 bpp hardware sprite with a 1-cycle output pipeline.
// Optional sticky sprite/background collision flag: VGA_SPRITE_COLLISION_EN.
module vga_sprite
    import vga_pkg::*;
#(
    parameter int HEIGHT = 16,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_active,
    input  logic          v_active,
    input  logic [CW-1:0] h_counter,
    input  logic [CW-1:0] v_counter,
    input  logic          cfg_we,
    input  logic [4:0]    cfg_addr,
    input  logic [31:0]   cfg_data,
    input  logic [1:0]    bg_color_index,
    output logic [1:0]    spr_index,
    output logic          spr_opaque,
    output logic          collision
);

    logic [CW-1:0]       sh_x, sh_y, lv_x, lv_y;
    logic                sh_en, lv_en;
    logic                row_we, pos_we, frame_start;
    logic signed [CW:0]  dy;
    logic                visible, hit, emit;
    logic [31:0]         row_data, shreg;
    logic [3:0]          pix_cnt;
    spr_state_t          state, state_nxt;
    color_idx_t          idx_p0;
    logic                opq_p0, show_p0;
    logic                unused_cfg;

    assign row_we      = cfg_we && (int'(cfg_addr) < HEIGHT);
    assign pos_we      = cfg_we && (cfg_addr == SPR_ADDR_POS);
    assign frame_start = (h_counter == '0) && (v_counter == '0);
    assign unused_cfg  = ^{cfg_data[15:CW], cfg_data[30:16+CW]};

    vga_sprite_rowmem #(.HEIGHT(HEIGHT)) u_rowmem (
        .clk     (clk),
        .reset   (reset),
        .we      (row_we),
        .wr_addr (cfg_addr[3:0]),
        .wr_data (cfg_data),
        .rd_addr (dy[3:0]),
        .rd_data (row_data)
    );

    // Software writes land in the shadow; live only changes at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= 1'b0;
            lv_x  <= '0;
            lv_y  <= '0;
            lv_en <= 1'b0;
        end else begin
            if (frame_start) begin
                lv_x  <= sh_x;
                lv_y  <= sh_y;
                lv_en <= sh_en;
            end
            if (pos_we) begin
                sh_x  <= cfg_data[CW-1:0];
                sh_y  <= cfg_data[16 +: CW];
                sh_en <= cfg_data[31];
            end
        end
    end

    // Negative or too-large dy means the current line misses the sprite.
    assign dy      = $signed({1'b0, v_counter}) - $signed({1'b0, lv_y});
    assign visible = !dy[CW] && (dy[CW-1:0] < CW'(HEIGHT));
    assign hit     = h_active && (h_counter == lv_x);

    // Pixel 0 goes out on the matching cycle so the output lands exactly
    // one clock after its h_counter; SHIFT then carries pixels 1..15.
    assign emit = ((state == ARMED) && hit) || (state == SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (lv_en) state_nxt = WAIT_LINE;
            WAIT_LINE: if (!h_active && v_active && visible) state_nxt = FETCH;
            FETCH:     state_nxt = ARMED;
            ARMED:     if (hit) state_nxt = SHIFT;
            SHIFT:     if (!h_active || (pix_cnt == 4'd15)) state_nxt = DONE;
            DONE:      if (!h_active) state_nxt = WAIT_LINE;
            default:   state_nxt = IDLE;
        endcase
        if (!lv_en) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pix_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH:   pix_cnt <= 4'd0;
                ARMED:   if (hit) pix_cnt <= 4'd1;
                SHIFT:   pix_cnt <= pix_cnt + 4'd1;
                default: pix_cnt <= pix_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            shreg <= row_data;
        end else if (emit) begin
            shreg <= {shreg[29:0], 2'b00};
        end
    end

    // Stage p0: pixel select; registered into the sprite outputs.
    assign show_p0 = emit && h_active && v_active && lv_en;
    assign idx_p0  = show_p0 ? color_idx_t'(shreg[31:30]) : color_idx_t'(2'd0);
    assign opq_p0  = show_p0 && (shreg[31:30] != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_index  <= '0;
            spr_opaque <= 1'b0;
        end else begin
            spr_index  <= idx_p0;
            spr_opaque <= opq_p0;
        end
    end

`ifdef VGA_SPRITE_COLLISION_EN
    logic coll_set, coll_clr;

    assign coll_set = opq_p0 && (bg_color_index != 2'd0);
    assign coll_clr = cfg_we && (cfg_addr == SPR_ADDR_CLR);

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else if (coll_set) begin
            collision <= 1'b1;
        end else if (coll_clr) begin
            collision <= 1'b0;
        end
    end
`else
    logic unused_bg;

    assign unused_bg = ^bg_color_index;
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite.sv
// Directed bench for vga_sprite: geometric per-cycle model plus row-pattern
// table and hand-written reset / clipping / collision sequences.
module tb_vga_sprite;
    import vga_pkg::*;

    localparam int HEIGHT  = 16;
    localparam int CW      = 10;
    localparam int H_TOTAL = 256;
    localparam int H_START = 32;
    localparam int V_START = 2;
`ifdef VGA_SPRITE_COLLISION_EN
    localparam logic C_EXP = 1'b1;
`else
    localparam logic C_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          h_active, v_active;
    logic [CW-1:0] h_counter, v_counter;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic [1:0]    bg_color_index;
    logic [1:0]    spr_index;
    logic          spr_opaque, collision;

    always #5 clk = ~clk;

    vga_sprite #(.HEIGHT(HEIGHT), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .h_active       (h_active),
        .v_active       (v_active),
        .h_counter      (h_counter),
        .v_counter      (v_counter),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .bg_color_index (bg_color_index),
        .spr_index      (spr_index),
        .spr_opaque     (spr_opaque),
        .collision      (collision)
    );

    typedef struct {
        logic [31:0] row;
        logic [31:0] exp_idx;
        logic [15:0] exp_opq;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          h;
        int          v;
        logic [4:0]  a;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          n_opq = 0;
    int          cap_v = -1;
    logic [31:0] cap_idx;
    logic [15:0] cap_opq;
    logic        bg_on = 1'b0;
    logic        chk_wrap = 1'b0;
    vec_t        tbl [16];
    wr_t         wq [$];

    logic [31:0]   m_rows [16];
    logic [CW-1:0] m_sx, m_sy, m_lx, m_ly;
    logic          m_se, m_le, m_coll;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rows[i] = '0;
        m_sx = '0; m_sy = '0; m_se = 1'b0;
        m_lx = '0; m_ly = '0; m_le = 1'b0;
        m_coll = 1'b0;
    endtask

    function automatic logic [31:0] pos_word(input int x, input int y, input logic en);
        return {en, 5'b0, 10'(y), 6'b0, 10'(x)};
    endfunction

    // One clock: compare outputs with the geometric model, then update it.
    task automatic step();
        int         dy, n;
        logic [1:0] e_idx;
        logic       e_opq, e_coll;
        @(posedge clk);
        #1;
        dy    = int'(v_counter) - int'(m_ly);
        n     = int'(h_counter) - int'(m_lx);
        e_idx = 2'd0;
        if (h_active && v_active && m_le && dy >= 0 && dy < HEIGHT && n >= 0 && n < 16)
            e_idx = m_rows[dy][31-2*n -: 2];
        e_opq  = (e_idx != 2'd0);
        e_coll = m_coll;
`ifdef VGA_SPRITE_COLLISION_EN
        if (e_opq && bg_color_index != 2'd0) e_coll = 1'b1;
        else if (cfg_we && cfg_addr == 5'd17) e_coll = 1'b0;
`endif
        m_coll = e_coll;
        checks++;
        if (spr_index !== e_idx || spr_opaque !== e_opq || collision !== e_coll) begin
            failures++;
            $display("FAIL pix v=%0d h=%0d got idx=%0d opq=%0d coll=%0d expected idx=%0d opq=%0d coll=%0d",
                     v_counter, h_counter, spr_index, spr_opaque, collision, e_idx, e_opq, e_coll);
        end
        if (spr_opaque === 1'b1) n_opq++;
        if (int'(v_counter) == cap_v && h_active && n >= 0 && n < 16) begin
            cap_idx[31-2*n -: 2] = spr_index;
            cap_opq[15-n]        = spr_opaque;
        end
        if (h_counter == '0 && v_counter == '0) begin
            m_lx = m_sx; m_ly = m_sy; m_le = m_se;
        end
        if (cfg_we) begin
            if (int'(cfg_addr) < HEIGHT) m_rows[cfg_addr[3:0]] = cfg_data;
            if (cfg_addr == 5'd16) begin
                m_sx = cfg_data[9:0]; m_sy = cfg_data[25:16]; m_se = cfg_data[31];
            end
        end
    endtask

    task automatic run_line(input int v, input int hmin, input int hmax);
        for (int h = hmin; h <= hmax; h++) begin
            h_counter = CW'(h);
            v_counter = CW'(v);
            h_active  = (h >= H_START);
            v_active  = (v >= V_START);
            cfg_we    = 1'b0;
            if (wq.size() > 0 && wq[0].v == v && wq[0].h == h) begin
                cfg_we   = 1'b1;
                cfg_addr = wq[0].a;
                cfg_data = wq[0].d;
                void'(wq.pop_front());
            end
            bg_color_index = 2'd0;
            if (bg_on && v == 51 && (h == 205 || h == 150)) bg_color_index = 2'd2;
            if (bg_on && v == 62 && h == 200) bg_color_index = 2'd1;
            step();
            if (chk_wrap && h == 0) check1("state_done_at_wrap", 32'(dut.state), 32'(DONE));
        end
    endtask

    task automatic run_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) run_line(v, 0, H_TOTAL - 1);
    endtask

    task automatic frame_head();
        run_line(0, 0, H_TOTAL - 1);
        run_line(1, 0, H_TOTAL - 1);
        run_lines(40, 49);
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'hC000_0003, 32'hC000_0003, 16'h8001};
        tbl[1]  = '{32'h5555_5555, 32'h5555_5555, 16'hFFFF};
        tbl[2]  = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 16'hFFFF};
        tbl[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF};
        tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 16'h0000};
        tbl[5]  = '{32'h1B1B_1B1B, 32'h1B1B_1B1B, 16'h7777};
        tbl[6]  = '{32'hE4E4_E4E4, 32'hE4E4_E4E4, 16'hEEEE};
        tbl[7]  = '{32'h3000_0000, 32'h3000_0000, 16'h4000};
        tbl[8]  = '{32'h0000_0001, 32'h0000_0001, 16'h0001};
        tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 16'h8000};
        tbl[10] = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 16'h3333};
        tbl[11] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 16'hCCCC};
        tbl[12] = '{32'h4000_0002, 32'h4000_0002, 16'h8001};
        tbl[13] = '{32'h0C00_0000, 32'h0C00_0000, 16'h2000};
        tbl[14] = '{32'h00FF_0000, 32'h00FF_0000, 16'h0F00};
        tbl[15] = '{32'h5000_0005, 32'h5000_0005, 16'hC003};

        reset = 1'b1;
        h_counter = CW'(10); v_counter = CW'(30);
        h_active = 1'b0; v_active = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; bg_color_index = 2'd0;
        model_reset();
        #2;
        check1("reset_idx", 32'(spr_index), 32'd0);
        check1("reset_opq", 32'(spr_opaque), 32'd0);
        check1("reset_coll", 32'(collision), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Frame 1: all rows 0x5555_5555 at x=100, y=50.
        for (int i = 0; i < 16; i++) cfg_wr(5'(i), 32'h5555_5555);
        cfg_wr(5'd16, pos_word(100, 50, 1'b1));
        check1("live_en_before_frame", 32'(dut.lv_en), 32'd0);
        n_opq = 0;
        frame_head();
        run_lines(50, 69);
        check1("frame1_opaque_count", 32'(n_opq), 32'd256);
        for (int i = 0; i < 16; i++) wq.push_back('{d: tbl[i].row, h: 40 + i, v: 70, a: 5'(i)});
        wq.push_back('{d: pos_word(200, 50, 1'b1), h: 60, v: 70, a: 5'd16});
        run_line(70, 0, H_TOTAL - 1);
        check1("live_x_after_midframe_write", 32'(dut.lv_x), 32'd100);
        run_line(71, 0, H_TOTAL - 1);

        // Frame 2: row-pattern table at x=200, collision sequences.
        bg_on = 1'b1;
        wq.push_back('{d: 32'h0, h: 10, v: 60, a: 5'd17});
        wq.push_back('{d: 32'h0, h: 200, v: 62, a: 5'd17});
        run_line(0, 0, H_TOTAL - 1);
        check1("live_x_next_frame", 32'(dut.lv_x), 32'd200);
        run_line(1, 0, H_TOTAL - 1);
        run_lines(40, 49);
        for (int i = 0; i < 16; i++) begin
            cap_v = 50 + i; cap_idx = '0; cap_opq = '0;
            run_line(50 + i, 0, H_TOTAL - 1);
            check1($sformatf("row%0d_idx", i), cap_idx, tbl[i].exp_idx);
            check1($sformatf("row%0d_opq", i), 32'(cap_opq), 32'(tbl[i].exp_opq));
            if (i == 1)  check1("coll_set", 32'(collision), 32'(C_EXP));
            if (i == 10) check1("coll_cleared", 32'(collision), 32'd0);
            if (i == 12) check1("coll_set_beats_clear", 32'(collision), 32'(C_EXP));
        end
        cap_v = -1;
        bg_on = 1'b0;
        run_lines(66, 69);
        for (int i = 0; i < 16; i++) wq.push_back('{d: 32'hFFFF_FFFF, h: 40 + i, v: 70, a: 5'(i)});
        wq.push_back('{d: pos_word(H_TOTAL - 4, 50, 1'b1), h: 60, v: 70, a: 5'd16});
        wq.push_back('{d: 32'h0, h: 70, v: 70, a: 5'd17});
        run_lines(70, 71);

        // Frame 3: right-edge clip at x=252, then reset while shifting.
        frame_head();
        n_opq = 0;
        run_line(50, 0, H_TOTAL - 1);
        chk_wrap = 1'b1;
        run_line(51, 0, 0);
        chk_wrap = 1'b0;
        check1("clip_opaque_count", 32'(n_opq), 32'd4);
        n_opq = 0;
        run_line(51, 1, 200);
        check1("no_wrap_next_line", 32'(n_opq), 32'd0);
        run_line(51, 201, H_TOTAL - 1);
        run_lines(52, 55);
        run_line(56, 0, 253);
        check1("state_shift_before_reset", 32'(dut.state), 32'(SHIFT));
        reset = 1'b1;
        #1;
        check1("midreset_idx", 32'(spr_index), 32'd0);
        check1("midreset_opq", 32'(spr_opaque), 32'd0);
        check1("midreset_coll", 32'(collision), 32'd0);
        check1("midreset_state", 32'(dut.state), 32'(IDLE));
        check1("midreset_live_x", 32'(dut.lv_x), 32'd0);
        check1("midreset_live_en", 32'(dut.lv_en), 32'd0);
        check1("midreset_rowmem", dut.u_rowmem.mem[3], 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_line(56, 254, H_TOTAL - 1);
        run_lines(57, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
